// File: rtl/sim_run_pkg.sv
// Shared types and default limits for the CPU simulation run controller.
// Imported by the controller and its switch-vector table.
package sim_run_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RESET,
        RUN,
        DONE
    } run_state_t;

    localparam logic [31:0] DEF_HALT_PC    = 32'hFFFF_FFFC;
    localparam int          DEF_MAX_CYCLES = 255;

endpackage

// File: rtl/sim_vec_table.sv
// Switch-vector table: NUM_VEC x SW_WIDTH registers, one write port,
// one combinational read port, cleared by the asynchronous reset.
module sim_vec_table
    import sim_run_pkg::*;
#(
    parameter int SW_WIDTH = 18,
    parameter int NUM_VEC  = 4,
    parameter int AW       = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [SW_WIDTH-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [SW_WIDTH-1:0] rdata
);

    // One extra bit so a power-of-two depth still fits.
    localparam logic [AW:0] DEPTH = (AW+1)'(NUM_VEC);

    logic [SW_WIDTH-1:0] mem [NUM_VEC];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                mem[i] <= '0;
            end
        end else if (we && ({1'b0, waddr} < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/sim_run_ctrl.sv
// Sequenced run controller: CPU reset pulse, switch-vector playback,
// stop on halt PC or cycle limit, probe capture at the stopping edge.
module sim_run_ctrl
    import sim_run_pkg::*;
#(
    parameter int          SW_WIDTH    = 18,
    parameter int          NUM_VEC     = 4,
    parameter int          HOLD_CYCLES = 16,
    parameter int          RST_CYCLES  = 1,
    parameter int          MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter logic [31:0] HALT_PC     = DEF_HALT_PC,
    localparam int         AW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                vec_we,
    input  logic [AW-1:0]       vec_addr,
    input  logic [SW_WIDTH-1:0] vec_data,
    input  logic [31:0]         pc_in,
    input  logic [31:0]         probe_in,
    output logic                cpu_rst_n,
    output logic [SW_WIDTH-1:0] sw_out,
    output logic [AW-1:0]       vec_idx,
    output logic [31:0]         cycle_count,
    output logic                done,
    output logic                timeout,
    output logic [31:0]         probe_capture
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_t state, state_d;

    logic [RW-1:0]       rcnt;
    logic [HW-1:0]       hold;
    logic                load, step, halt, tmo, wrap;
    logic [AW-1:0]       nidx, raddr;
    logic [SW_WIDTH-1:0] rdata;

    assign wrap = (hold == HW'(HOLD_CYCLES - 1));
    assign nidx = (vec_idx == AW'(NUM_VEC - 1)) ? '0 : vec_idx + AW'(1);

    // Entry load and vector advance never coincide, so one read port serves both.
    assign raddr = load ? '0 : nidx;

    sim_vec_table #(
        .SW_WIDTH (SW_WIDTH),
        .NUM_VEC  (NUM_VEC),
        .AW       (AW)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (vec_we),
        .waddr (vec_addr),
        .wdata (vec_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        load      = 1'b0;
        step      = 1'b0;
        halt      = 1'b0;
        tmo       = 1'b0;
        cpu_rst_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = RESET;
                    load    = 1'b1;
                end
            end
            RESET: begin
                if (rcnt == RW'(RST_CYCLES - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cpu_rst_n = 1'b1;
                halt      = (pc_in == HALT_PC);
                tmo       = !halt && (cycle_count == 32'(MAX_CYCLES - 1));
                step      = !halt;
                if (halt || tmo) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                cpu_rst_n = 1'b1;
                if (start) begin
                    state_d = RESET;
                    load    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt          <= '0;
            hold          <= '0;
            vec_idx       <= '0;
            sw_out        <= '0;
            cycle_count   <= '0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            probe_capture <= '0;
        end else begin
            if (load) begin
                rcnt        <= '0;
                hold        <= '0;
                vec_idx     <= '0;
                sw_out      <= rdata;
                cycle_count <= '0;
                done        <= 1'b0;
                timeout     <= 1'b0;
            end else if (state == RESET) begin
                rcnt <= rcnt + RW'(1);
            end else if (step) begin
                if (cycle_count != '1) begin
                    cycle_count <= cycle_count + 32'd1;
                end
                if (wrap) begin
                    hold    <= '0;
                    vec_idx <= nidx;
                    sw_out  <= rdata;
                end else begin
                    hold <= hold + HW'(1);
                end
            end
            if (halt || tmo) begin
                done          <= 1'b1;
                timeout       <= tmo;
                probe_capture <= probe_in;
            end
        end
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Randomized scoreboard bench for sim_run_ctrl against a count-based
// reference model of the run sequence.
module tb_sim_run_ctrl;

    localparam int          SW   = 18;
    localparam int          NV   = 2;
    localparam int          HOLD = 4;
    localparam int          RSTC = 2;
    localparam int          MAXC = 20;
    localparam logic [31:0] HPC  = 32'h40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        vec_we = 1'b0;
    logic [0:0]  vec_addr = '0;
    logic [17:0] vec_data = '0;
    logic [31:0] pc_in = '0;
    logic [31:0] probe_in = '0;

    logic        cpu_rst_n;
    logic [17:0] sw_out;
    logic [0:0]  vec_idx;
    logic [31:0] cycle_count;
    logic        done;
    logic        timeout;
    logic [31:0] probe_capture;

    sim_run_ctrl #(
        .SW_WIDTH    (SW),
        .NUM_VEC     (NV),
        .HOLD_CYCLES (HOLD),
        .RST_CYCLES  (RSTC),
        .MAX_CYCLES  (MAXC),
        .HALT_PC     (HPC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .vec_we        (vec_we),
        .vec_addr      (vec_addr),
        .vec_data      (vec_data),
        .pc_in         (pc_in),
        .probe_in      (probe_in),
        .cpu_rst_n     (cpu_rst_n),
        .sw_out        (sw_out),
        .vec_idx       (vec_idx),
        .cycle_count   (cycle_count),
        .done          (done),
        .timeout       (timeout),
        .probe_capture (probe_capture)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic [17:0] sw;
        int          idx;
        int          cc;
        logic        dn;
        logic        to;
        logic [31:0] pr;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: phase flags plus counts of edges, not the FSM.
    logic [17:0] m_tbl [NV];
    bit          m_inrst, m_run, m_fin;
    int          m_rleft, m_k, m_idx;
    logic [17:0] m_sw;
    bit          m_done, m_to;
    logic [31:0] m_pr;

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) m_tbl[i] = '0;
        m_inrst = 0; m_run = 0; m_fin = 0;
        m_rleft = 0; m_k = 0; m_idx = 0;
        m_sw = '0; m_done = 0; m_to = 0; m_pr = '0;
    endfunction

    function automatic void model_edge();
        if (!m_inrst && !m_run) begin
            if (start) begin
                m_inrst = 1; m_fin = 0; m_rleft = RSTC;
                m_k = 0; m_idx = 0; m_sw = m_tbl[0];
                m_done = 0; m_to = 0;
            end
        end else if (m_inrst) begin
            m_rleft--;
            if (m_rleft == 0) begin
                m_inrst = 0; m_run = 1;
            end
        end else begin
            if (pc_in == HPC) begin
                m_run = 0; m_fin = 1; m_done = 1; m_pr = probe_in;
            end else begin
                m_k++;
                if (m_k % HOLD == 0) begin
                    m_idx = (m_k / HOLD) % NV;
                    m_sw  = m_tbl[m_idx];
                end
                if (m_k == MAXC) begin
                    m_run = 0; m_fin = 1; m_done = 1; m_to = 1;
                    m_pr = probe_in;
                end
            end
        end
        if (vec_we && int'(vec_addr) < NV) m_tbl[vec_addr] = vec_data;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.rn = m_run || m_fin;
        e.sw = m_sw; e.idx = m_idx; e.cc = m_k;
        e.dn = m_done; e.to = m_to; e.pr = m_pr;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        q.push_back(snap());
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (cpu_rst_n !== e.rn || sw_out !== e.sw ||
                int'(vec_idx) != e.idx || cycle_count !== 32'(e.cc) ||
                done !== e.dn || timeout !== e.to ||
                probe_capture !== e.pr) begin
                miscompares++;
                $display("FAIL cycle t=%0t got/exp rstn=%b/%b sw=%0d/%0d idx=%0d/%0d cc=%0d/%0d done=%b/%b to=%b/%b probe=%h/%h",
                         $time, cpu_rst_n, e.rn, sw_out, e.sw, vec_idx, e.idx,
                         cycle_count, e.cc, done, e.dn, timeout, e.to,
                         probe_capture, e.pr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rstn"}, 32'(cpu_rst_n), 0);
        chk({tag, "_sw"}, 32'(sw_out), 0);
        chk({tag, "_idx"}, 32'(vec_idx), 0);
        chk({tag, "_cc"}, cycle_count, 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_to"}, 32'(timeout), 0);
        chk({tag, "_probe"}, probe_capture, 0);
    endtask

    function automatic logic [31:0] rpc();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) == 0) v = HPC ^ 32'(1 << $urandom_range(0, 7));
        if (v == HPC) v = 32'h44;
        return v;
    endfunction

    // halt_at: RUN edge on which pc_in equals HALT_PC (0 = never).
    task automatic run(input int halt_at, input bit noise);
        int n;
        start = 1; vec_we = 0; pc_in = rpc();
        step();
        start = 0;
        n = 0;
        while (!m_fin && n < 200) begin
            if (m_run && m_k == halt_at - 1) begin
                pc_in = HPC; probe_in = 32'hDEAD_BEEF;
            end else begin
                pc_in = rpc(); probe_in = $urandom;
            end
            start    = noise && ($urandom_range(0, 3) == 0);
            vec_we   = noise && ($urandom_range(0, 3) == 0);
            vec_addr = 1'($urandom_range(0, 1));
            vec_data = 18'($urandom);
            step();
            n++;
        end
        start = 0; vec_we = 0; pc_in = rpc(); probe_in = $urandom;
        step();
        step();
    endtask

    initial begin
        model_reset();
        #1 rst = 1;
        #2 chk_reset_values("por");
        @(negedge clk);
        rst = 0;

        repeat (3) step();
        chk("idle_rstn", 32'(cpu_rst_n), 0);

        vec_we = 1; vec_addr = 0; vec_data = 18'd12345;
        step();
        vec_addr = 1; vec_data = 18'd7;
        step();
        vec_we = 0;

        run(0, 0);
        chk("tmo_done", 32'(done), 1);
        chk("tmo_flag", 32'(timeout), 1);
        chk("tmo_cc", cycle_count, 20);

        run(6, 0);
        chk("halt6_done", 32'(done), 1);
        chk("halt6_to", 32'(timeout), 0);
        chk("halt6_cc", cycle_count, 5);
        chk("halt6_probe", probe_capture, 32'hDEAD_BEEF);

        run(20, 0);
        chk("halt20_to", 32'(timeout), 0);
        chk("halt20_done", 32'(done), 1);
        chk("halt20_cc", cycle_count, 19);

        run(9, 1);

        start = 1; pc_in = rpc();
        step();
        start = 0;
        repeat (RSTC + 7) begin
            pc_in = rpc();
            step();
        end
        @(negedge clk);
        #1 rst = 1;
        #1 chk_reset_values("midrun");
        rst = 0;
        model_reset();

        vec_we = 1; vec_addr = 0; vec_data = 18'($urandom);
        step();
        vec_addr = 1; vec_data = 18'($urandom);
        step();
        vec_we = 0;
        run(0, 0);
        chk("clean_cc", cycle_count, 20);

        for (int r = 0; r < 8; r++) begin
            run($urandom_range(0, 24), 1);
        end

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sim_run_ctrl.md
# sim_run_ctrl

Parametrised run controller for simulating the CSCE611 RISC-V CPU. It replaces a fixed reset pulse, constant switch value and fixed run time with a sequenced run. The block generates a CPU reset of programmable length and plays back a table of switch vectors at a fixed cadence. It stops the run on either a halt-PC match or a cycle limit, and captures a probe value (e.g. a register-file entry) on the stopping edge. It sits in the simulation top, between the bench and the CPU's `KEY[0]`/`SW` inputs.

## Interface
- `SW_WIDTH`, 18, width of switch vector driven to the CPU
- `NUM_VEC`, 4, switch-vector table depth (≥1)
- `HOLD_CYCLES`, 16, RUN cycles each vector is held (≥1)
- `RST_CYCLES`, 1, cycles the CPU reset is asserted (≥1)
- `MAX_CYCLES`, 255, RUN-cycle limit before timeout (≥1)
- `HALT_PC`, 32'hFFFF_FFFC, PC value that ends the run
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to begin a run
- `vec_we`  in  1  table write enable
- `vec_addr`  in  $clog2(NUM_VEC) (min 1)  table write index
- `vec_data`  in  SW_WIDTH  table write data
- `pc_in`  in  32  CPU fetch PC
- `probe_in`  in  32  value to capture at end of run
- `cpu_rst_n`  out  1  active-low CPU reset (to `KEY[0]`)
- `sw_out`  out  SW_WIDTH  switch vector to CPU
- `vec_idx`  out  $clog2(NUM_VEC) (min 1)  current vector index
- `cycle_count`  out  32  RUN cycles elapsed
- `done`  out  1  run finished (level)
- `timeout`  out  1  run ended by the cycle limit
- `probe_capture`  out  32  `probe_in` latched at the end of the run

## Operation
- States:
  - IDLE: entered on `rst`.
  - RESET: entered on `start` from IDLE or DONE. On entry, clear `cycle_count`, `vec_idx`, `done` and `timeout`, and load `sw_out` ← table[0]. Hold `cpu_rst_n` = 0.
  - RUN: entered after RESET has lasted RST_CYCLES cycles. `cpu_rst_n` = 1.
  - DONE: `cpu_rst_n` = 1; all outputs frozen.
- In IDLE, `cpu_rst_n` = 0, which holds the CPU in reset.
- In RUN, each cycle:
  - `cycle_count` increments.
  - An internal hold counter counts 0..HOLD_CYCLES-1. On wrap, `vec_idx` increments, wrapping NUM_VEC-1 → 0, and `sw_out` ← table[new idx].
- Halt: in RUN, if `pc_in` == HALT_PC → DONE. On the same edge, `done` ← 1 and `probe_capture` ← `probe_in`.
- Timeout: in RUN, if `cycle_count` == MAX_CYCLES-1 and there is no halt this cycle → DONE. On the same edge, `done` ← 1, `timeout` ← 1 and `probe_capture` ← `probe_in`.
- Halt and timeout in the same cycle: halt wins, so `timeout` = 0.
- `start` is ignored in RESET and RUN.
- Table:
  - Writes are accepted in every state.
  - `sw_out` only changes on a RESET entry or on a vector advance. A write to the live index therefore shows up at the next advance.
  - A write with `vec_addr` ≥ NUM_VEC is dropped.
- Widths:
  - `cycle_count` saturates at 2^32-1. It cannot saturate in practice while MAX_CYCLES < 2^32.
  - All comparisons are unsigned.

## Timing
- Reset values (async, immediate):
  - state IDLE
  - `cpu_rst_n` 0
  - `sw_out` 0
  - `vec_idx` 0
  - `cycle_count` 0
  - `done` 0
  - `timeout` 0
  - `probe_capture` 0
  - all table entries 0
- `start` sampled high at edge N:
  - RESET with `sw_out` = table[0] from edge N.
  - `cpu_rst_n` rises at edge N+RST_CYCLES.
- The first RUN edge gives `cycle_count` = 1.
- `sw_out` first advances on RUN edge HOLD_CYCLES.
- A run with no halt reaches DONE on RUN edge MAX_CYCLES, with `cycle_count` = MAX_CYCLES.
- A halt sampled at RUN edge k gives `done`=1 and `cycle_count`=k-1 after that edge; `cycle_count` does not increment on the stopping edge.
- `rst` during RUN: every output returns to its reset value asynchronously; the run is abandoned.
- `vec_we` is written at the clock edge and is visible to a RESET entry on the following edge.

## Structure
- Package `sim_run_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} run_state_t`
  - default constants for HALT_PC and MAX_CYCLES
- Sub-module `sim_vec_table`: a NUM_VEC×SW_WIDTH register file with async reset, one write port and one async read port.
- The FSM, counters and capture register live in `sim_run_ctrl`.

## Test plan
All scenarios use RST_CYCLES=2, HOLD_CYCLES=4, NUM_VEC=2, MAX_CYCLES=20, HALT_PC=32'h40.
- Write table[0]=18'd12345 and table[1]=18'd7, then pulse `start` → `cpu_rst_n` is low for 2 cycles. `sw_out`=12345 for RUN cycles 1–4, then 7 for cycles 5–8, then 12345 again (the index wraps).
- `pc_in` never equals 0x40 → `done`=1 and `timeout`=1 after RUN edge 20, with `cycle_count`=20 and `probe_capture`=`probe_in` on that edge.
- `pc_in`=0x40 with `probe_in`=32'hDEAD_BEEF on RUN edge 6 → `done`=1, `timeout`=0, `probe_capture`=DEADBEEF, `cycle_count`=5.
- `pc_in`=0x40 on RUN edge 20 → halt wins: `timeout`=0.
- Assert `rst` mid-RUN → all outputs return to their reset values. A later `start` gives a clean run with `cycle_count` starting from 0.
- `start` in DONE → re-enters RESET with `done`/`timeout` cleared. `start` during RUN → no effect.
